// File: rtl/code_issuer.sv
// Instruction buffer plus repeat-issue sequencer that drives packed control words to a control cell.
// Optional feature macro: CODE_ISSUER_ADDR_INC_EN (repeat issues step both memory addresses by one).
module code_issuer #(
  parameter int BLOCK_BITS = 3,
  parameter int ADDR_BITS  = 6,
  parameter int TOC_WIDTH  = 4,
  parameter int MODE_BITS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_BITS   = 4,
  parameter int BC         = (BLOCK_BITS + 1) * 2,
  parameter int CW         = TOC_WIDTH + 2 * (BC + ADDR_BITS + MODE_BITS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TOC_WIDTH-1:0] in_opcode,
  input  logic [MODE_BITS-1:0] in_mode_a,
  input  logic [MODE_BITS-1:0] in_mode_b,
  input  logic [BC-1:0]        in_offset_a,
  input  logic [BC-1:0]        in_offset_b,
  input  logic [ADDR_BITS-1:0] in_addr_a,
  input  logic [ADDR_BITS-1:0] in_addr_b,
  input  logic [REP_BITS-1:0]  in_repeat,
  output logic [CW-1:0]        code_out,
  output logic                 busy
);

  localparam int WW         = CW - 1;
  localparam int EW         = WW + REP_BITS;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int ADDR_B_LSB = BC;
  localparam int ADDR_A_LSB = 2 * BC + ADDR_BITS + MODE_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

`ifdef CODE_ISSUER_ADDR_INC_EN
  function automatic logic [WW-1:0] bump_addrs(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = w;
    r[ADDR_A_LSB +: ADDR_BITS] = w[ADDR_A_LSB +: ADDR_BITS] + ADDR_BITS'(1);
    r[ADDR_B_LSB +: ADDR_BITS] = w[ADDR_B_LSB +: ADDR_BITS] + ADDR_BITS'(1);
    return r;
  endfunction
`endif

  state_t              state_q, state_d;
  logic [REP_BITS-1:0] rep_q, rep_d;
  logic [WW-1:0]       active_q, active_d;
  logic [CW-1:0]       code_q, code_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];

  logic                push_s;
  logic                pop_s;
  logic                empty_s;
  logic [EW-1:0]       in_entry_s;
  logic [EW-1:0]       head_s;
  logic [WW-1:0]       next_word_s;

  assign in_entry_s = {in_repeat, in_opcode, in_mode_a, in_addr_a, in_offset_a,
                       in_mode_b, in_addr_b, in_offset_b};
  assign empty_s    = (count_q == {CNT_W{1'b0}});
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push_s     = in_valid & in_ready;
  assign head_s     = mem_q[rd_ptr_q];
  assign code_out   = code_q;
  assign busy       = !empty_s || (state_q == ISSUE);

`ifdef CODE_ISSUER_ADDR_INC_EN
  assign next_word_s = bump_addrs(active_q);
`else
  assign next_word_s = active_q;
`endif

  // Sequencer: pops the head when idle, then re-issues it rep_cnt more times; en=0 freezes it.
  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    active_d = active_q;
    code_d   = {CW{1'b0}};
    pop_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !empty_s) begin
          pop_s    = 1'b1;
          active_d = head_s[WW-1:0];
          rep_d    = head_s[EW-1 -: REP_BITS];
          code_d   = {1'b1, head_s[WW-1:0]};
          state_d  = (head_s[EW-1 -: REP_BITS] != {REP_BITS{1'b0}}) ? ISSUE : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (en) begin
          active_d = next_word_s;
          code_d   = {1'b1, next_word_s};
          rep_d    = rep_q - REP_BITS'(1);
          state_d  = (rep_q == REP_BITS'(1)) ? IDLE : ISSUE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
        rep_d   = {REP_BITS{1'b0}};
      end
    endcase
  end

  // Buffer pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // State registers; reset discards everything buffered or in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rep_q    <= {REP_BITS{1'b0}};
      active_q <= {WW{1'b0}};
      code_q   <= {CW{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      active_q <= active_d;
      code_q   <= code_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage write port.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= in_entry_s;
    end
  end

endmodule

// File: tb/tb_code_issuer.sv
// Randomized self-checking bench for code_issuer against a queue-based reference model.
module tb_code_issuer;

  logic        clk = 1'b0;
  logic        rst, en, in_valid;
  logic [3:0]  in_opcode, in_repeat;
  logic [1:0]  in_mode_a, in_mode_b;
  logic [7:0]  in_offset_a, in_offset_b;
  logic [5:0]  in_addr_a, in_addr_b;
  logic        in_ready, busy;
  logic [36:0] code_out;

  always #5 clk = ~clk;

  code_issuer dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_mode_a(in_mode_a), .in_mode_b(in_mode_b),
    .in_offset_a(in_offset_a), .in_offset_b(in_offset_b),
    .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .in_repeat(in_repeat),
    .code_out(code_out), .busy(busy)
  );

  typedef struct {
    logic [3:0] op;
    logic [1:0] ma, mb;
    logic [7:0] oa, ob;
    logic [5:0] aa, ab;
    logic [3:0] rep;
  } ent_t;

  int          vectors = 0;
  int          miscompares = 0;
  ent_t        q[$];
  ent_t        act;
  int          remaining = 0;
  int          nidx = 0;
  logic [36:0] exp_code = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [36:0] build(input ent_t e, input int n);
    logic [5:0] a, b;
`ifdef CODE_ISSUER_ADDR_INC_EN
    a = e.aa + 6'(n);
    b = e.ab + 6'(n);
`else
    a = e.aa;
    b = e.ab;
`endif
    return {1'b1, e.op, e.ma, a, e.oa, e.mb, b, e.ob};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] aa,
                       input logic [5:0] ab, input logic [3:0] rep);
    in_valid    = v;
    in_opcode   = op;
    in_addr_a   = aa;
    in_addr_b   = ab;
    in_repeat   = rep;
    in_mode_a   = 2'($urandom);
    in_mode_b   = 2'($urandom);
    in_offset_a = 8'($urandom);
    in_offset_b = 8'($urandom);
  endtask

  // One clock: advance the reference model with the sampled inputs, then compare outputs.
  task automatic step();
    ent_t cur;
    logic acc;
    @(posedge clk);
    cur.op = in_opcode; cur.ma = in_mode_a; cur.mb = in_mode_b;
    cur.oa = in_offset_a; cur.ob = in_offset_b;
    cur.aa = in_addr_a; cur.ab = in_addr_b; cur.rep = in_repeat;
    if (rst) begin
      q.delete();
      remaining = 0;
      exp_code  = '0;
    end else begin
      acc = in_valid && (q.size() < 4);
      if (!en) begin
        exp_code = '0;
      end else if (remaining > 0) begin
        nidx++;
        exp_code = build(act, nidx);
        remaining--;
      end else if (q.size() > 0) begin
        act       = q.pop_front();
        nidx      = 0;
        remaining = int'(act.rep);
        exp_code  = build(act, 0);
      end else begin
        exp_code = '0;
      end
      if (acc) q.push_back(cur);
    end
    #1;
    check_eq("code_out", 64'(code_out), 64'(exp_code));
    check_eq("in_ready", 64'(in_ready), 64'(q.size() < 4));
    check_eq("busy", 64'(busy), 64'((q.size() > 0) || (remaining > 0)));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    drive(1'b0, 4'd0, 6'd0, 6'd0, 4'd0);
    step(); step();
    rst = 1'b0; en = 1'b1;
    repeat (3) step();

    // single issue latency
    drive(1'b1, 4'b1000, 6'd5, 6'd9, 4'd0);
    step();
    in_valid = 1'b0;
    step();
    check_eq("lat_valid", 64'(code_out[36]), 64'd1);
    check_eq("lat_opcode", 64'(code_out[35:32]), 64'd8);
    check_eq("lat_addr_a", 64'(code_out[29:24]), 64'd5);
    check_eq("lat_addr_b", 64'(code_out[13:8]), 64'd9);
    step();
    check_eq("lat_nop", 64'(code_out), 64'd0);

    // fill with en low, fifth push refused, then drain in order
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 1), 6'($urandom), 6'($urandom), 4'd0);
      step();
      if (i == 3) check_eq("full_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; en = 1'b1;
    repeat (6) step();

    // repeat issues with address wrap
    drive(1'b1, 4'd3, 6'd63, 6'd0, 4'd2);
    step();
    in_valid = 1'b0;
    step();
    check_eq("rep0_addr_a", 64'(code_out[29:24]), 64'd63);
    step();
`ifdef CODE_ISSUER_ADDR_INC_EN
    check_eq("rep1_addr_a", 64'(code_out[29:24]), 64'd0);
    check_eq("rep1_addr_b", 64'(code_out[13:8]), 64'd1);
`else
    check_eq("rep1_addr_a", 64'(code_out[29:24]), 64'd63);
    check_eq("rep1_addr_b", 64'(code_out[13:8]), 64'd0);
`endif
    repeat (3) step();

    // en dropped mid-repeat
    drive(1'b1, 4'd5, 6'd10, 6'd20, 4'd3);
    step();
    in_valid = 1'b0;
    step(); step();
    en = 1'b0;
    step(); step();
    en = 1'b1;
    repeat (4) step();

    // reset during ISSUE with three entries buffered
    drive(1'b1, 4'd6, 6'd1, 6'd2, 4'd3);
    step();
    in_valid = 1'b0;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(9 + i), 6'($urandom), 6'($urandom), 4'd1);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_code", 64'(code_out), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    en = 1'b1;
    repeat (4) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom), 6'($urandom),
            4'($urandom_range(0, 3)));
      step();
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    repeat (25) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_issuer.md
CODE_ISSUER -- requirements
Module: code_issuer

Interface
REQ-001 SHALL have parameters: BLOCK_BITS, default 3, symmetric-axis address bits; ADDR_BITS, default 6, memory address bits; TOC_WIDTH, default 4, tile opcode width; MODE_BITS, default 2, viewer mode bits; FIFO_DEPTH, default 4, instruction buffer entries (power of 2); REP_BITS, default 4, repeat-count width.
REQ-002 SHALL derive BC = (BLOCK_BITS+1)*2 (8) and CW = TOC_WIDTH+2*(BC+ADDR_BITS+MODE_BITS)+1 (37).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  issue enable; low inserts bubbles.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  instruction buffer can accept.
REQ-008 in_opcode  input  TOC_WIDTH  tile opcode.
REQ-009 in_mode_a / in_mode_b  input  MODE_BITS each  viewer modes.
REQ-010 in_offset_a / in_offset_b  input  BC each  viewer offsets.
REQ-011 in_addr_a / in_addr_b  input  ADDR_BITS each  memory addresses.
REQ-012 in_repeat  input  REP_BITS  extra issue count (0 = issue once).
REQ-013 code_out  output  CW  registered packed control word to control cell.
REQ-014 busy  output  1  high when buffer non-empty or repeat in progress.

Function
REQ-015 code_out packing, LSB first, SHALL be: [BC-1:0] offset_b, then addr_b, mode_b, offset_a, addr_a, mode_a, opcode, then MSB valid flag (defaults: [7:0],[13:8],[15:14],[23:16],[29:24],[31:30],[35:32],[36]).
REQ-016 Handshake: transfer occurs on rising edge with in_valid & in_ready; in_ready = buffer not full, independent of in_valid and en.
REQ-017 Full buffer SHALL not accept even if a pop occurs the same cycle; empty buffer with push SHALL not bypass (minimum latency: accepted at edge k, on code_out after edge k+1).
REQ-018 FSM states IDLE (no active instruction) and ISSUE (active instruction, rep_cnt remaining).
REQ-019 IDLE, en=1, buffer non-empty: pop head, drive its word with valid=1, load rep_cnt=in_repeat field; go ISSUE if field>0, else stay IDLE.
REQ-020 ISSUE, en=1: re-drive active word with valid=1, decrement rep_cnt; when it reaches 0 after this issue, return IDLE; next instruction pops earliest the following edge (no gap beyond this).
REQ-021 Any cycle not issuing (en=0, or IDLE with empty buffer) SHALL drive code_out all zeros (NOP, valid=0); en=0 freezes FSM, rep_cnt, and buffer read pointer.
REQ-022 Buffer pointers SHALL wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-023 busy = (buffer non-empty) | (state==ISSUE).

Reset
REQ-024 On rst=1 at a rising edge: state=IDLE, rep_cnt=0, pointers and occupancy=0, code_out=0, in_ready=1 after the edge, busy=0; buffered and in-flight instructions SHALL be discarded.
REQ-025 Reset SHALL override simultaneous push, pop, and en.

Configuration
REQ-026 Macro CODE_ISSUER_ADDR_INC_EN defined: each repeat issue SHALL increment addr_a and addr_b by 1 modulo 2^ADDR_BITS relative to the previous issue; other fields unchanged.
REQ-027 Macro undefined: repeat issues SHALL drive identical words.

Verification
REQ-028 Reset then idle, en=1 -> code_out=0, in_ready=1, busy=0 every cycle.
REQ-029 Push opcode 4'b1000, addr_a=5, addr_b=9, repeat=0 at edge k -> after edge k+1 code_out[36]=1, [35:32]=8, [29:24]=5, [13:8]=9; after edge k+2 code_out=0.
REQ-030 Push 5 instructions back-to-back with en=0 -> 4 accepted, in_ready=0 at fifth; raise en -> 4 words issued in push order on consecutive cycles.
REQ-031 Push repeat=2, addr_a=63, addr_b=0 -> 3 consecutive issues; with CODE_ISSUER_ADDR_INC_EN addr_a 63,0,1 and addr_b 0,1,2; without it, 63/0 thrice.
REQ-032 Drop en for 2 cycles mid-repeat (repeat=3) -> two zero words inserted, remaining issues resume, total 4 issues.
REQ-033 Assert rst during ISSUE with 3 entries buffered -> next cycle code_out=0, busy=0, in_ready=1; no discarded instruction ever appears.
